// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
//   NUM_DIGITS : digits in one scan frame
//   DIG_W      : width of one digit code
//   SEL_W      : width of the digit index
//   DATA_W     : width of a full data bank
//   EN_RESET   : enable-bank value after reset (all digits lit)
package seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int DIG_W      = 4;
    localparam int SEL_W      = 3;
    localparam int DATA_W     = NUM_DIGITS * DIG_W;
    localparam logic [NUM_DIGITS-1:0] EN_RESET = 8'hFF;
endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high during the last clock of each PRESCALE-clock slot
module scan_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);
endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed display scanner with frame-synchronous,
// double-buffered updates.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : single-cycle write strobe for wr_data / wr_en
//   wr_data     : eight 4-bit digit codes, digit k at [4k+3:4k]
//   wr_en       : per-digit enable, bit k for digit k
//   dig_val     : code of the digit being scanned
//   dig_sel     : index of the digit being scanned
//   dig_en      : enable bit of the digit being scanned
//   pend        : an update sits in the shadow bank awaiting the frame edge
//   frame_tick  : one-cycle pulse on the first clock of a new frame
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [NUM_DIGITS-1:0] wr_en,
    output logic [DIG_W-1:0]      dig_val,
    output logic [SEL_W-1:0]      dig_sel,
    output logic                  dig_en,
    output logic                  pend,
    output logic                  frame_tick
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    logic                  w_tick;
    logic                  w_boundary;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_pend;
    logic                  r_frame_tick;
    logic [DATA_W-1:0]     r_shadow_data;
    logic [NUM_DIGITS-1:0] r_shadow_en;
    logic [DATA_W-1:0]     r_active_data;
    logic [NUM_DIGITS-1:0] r_active_en;
    logic [DIG_W-1:0]      w_nibble [NUM_DIGITS];

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // The edge that ends digit 7 is the only point the active bank may change.
    assign w_boundary = w_tick && (r_sel == LAST_SEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_tick) begin
                r_sel <= r_sel + 1'b1;   // natural wrap 7 -> 0
            end
            r_frame_tick <= w_boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= 1'b0;
            r_shadow_data <= '0;
            r_shadow_en   <= EN_RESET;
            r_active_data <= '0;
            r_active_en   <= EN_RESET;
        end else begin
            if (load) begin
                r_shadow_data <= wr_data;
                r_shadow_en   <= wr_en;
            end
            if (w_boundary) begin
                // A load landing on the boundary bypasses the shadow bank so
                // it is not delayed by a whole frame.
                if (load) begin
                    r_active_data <= wr_data;
                    r_active_en   <= wr_en;
                end else if (r_pend) begin
                    r_active_data <= r_shadow_data;
                    r_active_en   <= r_shadow_en;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Split the active bank into digit slots; outputs depend on registers only.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
        assign w_nibble[gi] = r_active_data[gi*DIG_W +: DIG_W];
    end

    assign dig_val    = w_nibble[r_sel];
    assign dig_en     = r_active_en[r_sel];
    assign dig_sel    = r_sel;
    assign pend       = r_pend;
    assign frame_tick = r_frame_tick;
endmodule
